// File: rtl/lmsm_sequencer_pkg.sv
// Shared definitions for the LM/SM multi-register transfer controller:
// default geometry of the register file, sequencer state encodings and the
// LM/SM opcodes that decode matches on.
package lmsm_sequencer_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned NREGS_DEF  = 8;
  localparam int unsigned AW_DEF     = 3;

  // Opcodes steered to this sequencer by decode
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_FINISH = 2'd2
  } seq_state_t;

endpackage

// File: rtl/lowest_set_bit_enc.sv
// Combinational priority encoder: index of the lowest set bit of a register
// mask plus a flag telling whether any bit is set. Also used by decode for
// mask checks.
module lowest_set_bit_enc #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3
) (
  input  logic [NREGS-1:0] mask_i,
  output logic [AW-1:0]    idx_o,
  output logic             valid_o
);

  // First set bit scanning upward from bit 0 wins
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (mask_i[i] && !valid_o) begin
        idx_o   = AW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks a latched register mask from R0 upward and issues
// one memory request per selected register at consecutive word addresses.
// Loads write back into the register file one cycle after each ack; stores
// read the register file through port 2 and forward the data to memory.
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned AW     = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic [NREGS-1:0]  reg_mask,
  input  logic [DATA_W-1:0] base_addr,
  output logic [AW-1:0]     rf_a2,
  input  logic [DATA_W-1:0] rf_d2,
  output logic [AW-1:0]     rf_a3,
  output logic [DATA_W-1:0] rf_d3,
  output logic              rf_d3_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              pc_hold,
  output logic              done,
  output logic [AW:0]       xfer_count
);

  seq_state_t        state_q, state_d;
  logic              is_load_q, is_load_d;
  logic [NREGS-1:0]  rem_mask_q, rem_mask_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [AW:0]       xfer_q, xfer_d;
  logic              wb_en_q, wb_en_d;
  logic [AW-1:0]     wb_idx_q, wb_idx_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic [NREGS-1:0]  next_mask;
  logic [AW-1:0]     cur_idx;
  logic              cur_vld;

  // Register currently being serviced: lowest bit still pending in the mask
  lowest_set_bit_enc #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_lsb_enc (
    .mask_i  (rem_mask_q),
    .idx_o   (cur_idx),
    .valid_o (cur_vld)
  );

  // State register and latched operation context; reset also drops any pending writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      is_load_q  <= 1'b0;
      rem_mask_q <= '0;
      addr_q     <= '0;
      xfer_q     <= '0;
      wb_en_q    <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_load_q  <= is_load_d;
      rem_mask_q <= rem_mask_d;
      addr_q     <= addr_d;
      xfer_q     <= xfer_d;
      wb_en_q    <= wb_en_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Next-state: latch on start, retire one register per ack, finish when the mask empties
  always_comb begin
    state_d    = state_q;
    is_load_d  = is_load_q;
    rem_mask_d = rem_mask_q;
    addr_d     = addr_q;
    xfer_d     = xfer_q;
    wb_en_d    = 1'b0;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;

    next_mask          = rem_mask_q;
    next_mask[cur_idx] = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_load_d  = is_load;
          rem_mask_d = reg_mask;
          addr_d     = base_addr;
          xfer_d     = '0;
          state_d    = (reg_mask == '0) ? ST_FINISH : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          rem_mask_d = next_mask;
          addr_d     = addr_q + DATA_W'(1);
          xfer_d     = xfer_q + (AW+1)'(1);
          if (is_load_q) begin
            wb_en_d   = 1'b1;
            wb_idx_d  = cur_idx;
            wb_data_d = mem_rdata;
          end
          if (next_mask == '0) begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: request fields are combinational from the held context so they stay stable until ack
  always_comb begin
    mem_req    = (state_q == ST_ACCESS) && cur_vld;
    mem_we     = mem_req && !is_load_q;
    mem_addr   = addr_q;
    rf_a2      = cur_idx;
    mem_wdata  = rf_d2;
    rf_a3      = wb_idx_q;
    rf_d3      = wb_data_q;
    rf_d3_en   = wb_en_q;
    done       = (state_q == ST_FINISH);
    busy       = (state_q != ST_IDLE) || wb_en_q;
    pc_hold    = busy;
    xfer_count = xfer_q;
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer. A driver task runs one operation
// against a register-file array and an address-hashed memory, logging every
// request, writeback and the done cycle; the test tasks compare those logs to
// expectations derived from the transfer rules (ascending register order,
// consecutive wrapping addresses, writeback one cycle after ack).
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic [7:0]  reg_mask;
  logic [15:0] base_addr;
  logic [2:0]  rf_a2;
  logic [15:0] rf_d2;
  logic [2:0]  rf_a3;
  logic [15:0] rf_d3;
  logic        rf_d3_en;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        pc_hold;
  logic        done;
  logic [3:0]  xfer_count;

  logic [15:0] rf_model [8];
  logic [15:0] salt;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [2:0]  a2;
    logic [15:0] wdata;
    int          cyc;
  } req_t;

  typedef struct packed {
    logic [2:0]  a3;
    logic [15:0] d3;
    int          cyc;
  } wr_t;

  req_t        req_log[$];
  wr_t         wr_log[$];
  int          done_cyc;
  logic [3:0]  xfer_at_done;
  int          busy_bad;
  int          stable_bad;
  int          post_busy;
  int          pc_hold_bad;
  bit          timed_out;
  logic [46:0] ab_snap;

  function automatic logic [15:0] mem_fn(input logic [15:0] a, input logic [15:0] s);
    return (a * 16'h9E37) ^ s;
  endfunction

  always #5 clk = ~clk;

  assign rf_d2     = rf_model[rf_a2];
  assign mem_rdata = mem_fn(mem_addr, salt);

  lmsm_sequencer #(
    .DATA_W (16),
    .NREGS  (8),
    .AW     (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_load    (is_load),
    .reg_mask   (reg_mask),
    .base_addr  (base_addr),
    .rf_a2      (rf_a2),
    .rf_d2      (rf_d2),
    .rf_a3      (rf_a3),
    .rf_d3      (rf_d3),
    .rf_d3_en   (rf_d3_en),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .pc_hold    (pc_hold),
    .done       (done),
    .xfer_count (xfer_count)
  );

  // Runs one operation; cycle 1 is the cycle after the edge that samples start.
  task automatic run_op(input bit ld, input logic [7:0] mask, input logic [15:0] base,
                        input int dmin, input int dmax, input bit spam, input int abort_after);
    int   cyc, wait_cnt, target, acks;
    bit   finished, have_first;
    logic [15:0] f_addr, f_wd;
    logic [2:0]  f_a2;
    logic        f_we;
    req_log.delete();
    wr_log.delete();
    done_cyc = -1; xfer_at_done = 'x; busy_bad = 0; stable_bad = 0;
    post_busy = 0; pc_hold_bad = 0; timed_out = 1'b0; ab_snap = 'x;
    salt = 16'($urandom);
    @(negedge clk);
    start = 1'b1; is_load = ld; reg_mask = mask; base_addr = base; mem_ack = 1'b0;
    @(negedge clk);
    cyc = 1; wait_cnt = 0; acks = 0; finished = 1'b0; have_first = 1'b0;
    target = int'($urandom_range(dmax, dmin));
    f_addr = '0; f_wd = '0; f_a2 = '0; f_we = 1'b0;
    while (!finished) begin
      if (pc_hold !== busy) pc_hold_bad++;
      if (done_cyc < 0 && busy !== 1'b1) busy_bad++;
      if (done_cyc >= 0 && (busy !== 1'b0 || mem_req !== 1'b0 || rf_d3_en !== 1'b0 || done !== 1'b0))
        post_busy++;
      if (rf_d3_en === 1'b1) wr_log.push_back('{rf_a3, rf_d3, cyc});
      if (done_cyc < 0 && done === 1'b1) begin
        done_cyc = cyc;
        xfer_at_done = xfer_count;
        if (mem_req !== 1'b0) post_busy++;
      end
      mem_ack = 1'b0;
      if (abort_after > 0 && acks == abort_after) begin
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ab_snap = {busy, pc_hold, done, mem_req, rf_d3_en, rf_a2, rf_a3, rf_d3, mem_addr, xfer_count};
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          if (busy !== 1'b0 || mem_req !== 1'b0 || rf_d3_en !== 1'b0 || done !== 1'b0) post_busy++;
        end
        finished = 1'b1;
      end else begin
        if (done_cyc < 0 && mem_req === 1'b1) begin
          if (!have_first) begin
            f_addr = mem_addr; f_a2 = rf_a2; f_we = mem_we; f_wd = mem_wdata; have_first = 1'b1;
          end else if (mem_addr !== f_addr || rf_a2 !== f_a2 || mem_we !== f_we || mem_wdata !== f_wd) begin
            stable_bad++;
          end
          if (wait_cnt >= target) begin
            mem_ack = 1'b1;
            req_log.push_back('{mem_addr, mem_we, rf_a2, mem_wdata, cyc});
            wait_cnt = 0; acks++; have_first = 1'b0;
            target = int'($urandom_range(dmax, dmin));
          end else begin
            wait_cnt++;
          end
        end
        start = spam && (done_cyc < 0 || cyc == done_cyc);
        if (spam) begin
          is_load = 1'($urandom_range(0, 1)); reg_mask = 8'($urandom); base_addr = 16'($urandom);
        end
        if (done_cyc >= 0 && cyc >= done_cyc + 2) finished = 1'b1;
        if (cyc >= 400) begin timed_out = 1'b1; finished = 1'b1; end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [46:0] snap;
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; is_load = 1'b0; reg_mask = '0; base_addr = '0;
    repeat (3) @(negedge clk);
    snap = {busy, pc_hold, done, mem_req, rf_d3_en, rf_a2, rf_a3, rf_d3, mem_addr, xfer_count};
    vectors++;
    if (snap !== '0) begin miscompares++; $display("FAIL reset_outputs: got %h expected 0", snap); end
    rst = 1'b0;
    @(negedge clk);
    snap = {busy, pc_hold, done, mem_req, rf_d3_en, rf_a2, rf_a3, rf_d3, mem_addr, xfer_count};
    vectors++;
    if (snap !== '0) begin miscompares++; $display("FAIL idle_after_reset: got %h expected 0", snap); end
  endtask

  task automatic test_lm_basic();
    logic [2:0] exp_idx [3] = '{3'd0, 3'd2, 3'd7};
    for (int i = 0; i < 8; i++) rf_model[i] = 16'($urandom);
    run_op(1'b1, 8'b1000_0101, 16'h0040, 0, 0, 1'b0, 0);
    vectors++;
    if (req_log.size() != 3 || wr_log.size() != 3) begin
      miscompares++;
      $display("FAIL lm_counts: got req=%0d wr=%0d expected 3/3", req_log.size(), wr_log.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (req_log[k].addr !== 16'(16'h0040 + k) || req_log[k].we !== 1'b0 || req_log[k].cyc != k + 1) begin
          miscompares++;
          $display("FAIL lm_req%0d: got addr=%h we=%b cyc=%0d expected addr=%h we=0 cyc=%0d",
                   k, req_log[k].addr, req_log[k].we, req_log[k].cyc, 16'(16'h0040 + k), k + 1);
        end
        vectors++;
        if (wr_log[k].a3 !== exp_idx[k] || wr_log[k].d3 !== mem_fn(16'(16'h0040 + k), salt) || wr_log[k].cyc != k + 2) begin
          miscompares++;
          $display("FAIL lm_wr%0d: got R%0d=%h cyc=%0d expected R%0d=%h cyc=%0d", k, wr_log[k].a3, wr_log[k].d3,
                   wr_log[k].cyc, exp_idx[k], mem_fn(16'(16'h0040 + k), salt), k + 2);
        end
      end
    end
    vectors++;
    if (done_cyc != 4 || xfer_at_done !== 4'd3) begin
      miscompares++;
      $display("FAIL lm_done: got cyc=%0d xfer=%0d expected cyc=4 xfer=3", done_cyc, xfer_at_done);
    end
    vectors++;
    if (busy_bad != 0 || post_busy != 0 || pc_hold_bad != 0) begin
      miscompares++;
      $display("FAIL lm_busy: got bad=%0d post=%0d pch=%0d expected 0/0/0", busy_bad, post_busy, pc_hold_bad);
    end
  endtask

  task automatic test_sm_wrap();
    logic [15:0] exp_addr [2] = '{16'hFFFF, 16'h0000};
    logic [15:0] exp_data [2] = '{16'h001F, 16'hFFFF};
    logic [2:0]  exp_idx  [2] = '{3'd3, 3'd4};
    for (int i = 0; i < 8; i++) rf_model[i] = 16'($urandom);
    rf_model[3] = 16'h001F;
    rf_model[4] = 16'hFFFF;
    run_op(1'b0, 8'b0001_1000, 16'hFFFF, 0, 0, 1'b0, 0);
    vectors++;
    if (req_log.size() != 2 || wr_log.size() != 0) begin
      miscompares++;
      $display("FAIL sm_counts: got req=%0d wr=%0d expected 2/0", req_log.size(), wr_log.size());
    end else begin
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (req_log[k].addr !== exp_addr[k] || req_log[k].wdata !== exp_data[k] ||
            req_log[k].we !== 1'b1 || req_log[k].a2 !== exp_idx[k]) begin
          miscompares++;
          $display("FAIL sm_req%0d: got a=%h d=%h we=%b r=%0d expected a=%h d=%h we=1 r=%0d", k, req_log[k].addr,
                   req_log[k].wdata, req_log[k].we, req_log[k].a2, exp_addr[k], exp_data[k], exp_idx[k]);
        end
      end
    end
    vectors++;
    if (done_cyc != 3 || xfer_at_done !== 4'd2) begin
      miscompares++;
      $display("FAIL sm_done: got cyc=%0d xfer=%0d expected cyc=3 xfer=2", done_cyc, xfer_at_done);
    end
  endtask

  task automatic test_zero_mask();
    run_op(1'($urandom_range(0, 1)), 8'h00, 16'($urandom), 0, 0, 1'b0, 0);
    vectors++;
    if (req_log.size() != 0 || wr_log.size() != 0) begin
      miscompares++;
      $display("FAIL zero_traffic: got req=%0d wr=%0d expected 0/0", req_log.size(), wr_log.size());
    end
    vectors++;
    if (done_cyc != 1 || xfer_at_done !== 4'd0) begin
      miscompares++;
      $display("FAIL zero_done: got cyc=%0d xfer=%0d expected cyc=1 xfer=0", done_cyc, xfer_at_done);
    end
    vectors++;
    if (busy_bad != 0 || post_busy != 0) begin
      miscompares++;
      $display("FAIL zero_busy_width: got bad=%0d post=%0d expected 0/0", busy_bad, post_busy);
    end
  endtask

  task automatic test_lm_wait();
    logic [15:0] base;
    base = 16'($urandom);
    run_op(1'b1, 8'hFF, base, 2, 2, 1'b0, 0);
    vectors++;
    if (stable_bad != 0) begin
      miscompares++;
      $display("FAIL wait_stable: got %0d changes expected 0", stable_bad);
    end
    vectors++;
    if (wr_log.size() != 8 || req_log.size() != 8) begin
      miscompares++;
      $display("FAIL wait_counts: got req=%0d wr=%0d expected 8/8", req_log.size(), wr_log.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        vectors++;
        if (wr_log[k].a3 !== 3'(k) || wr_log[k].d3 !== mem_fn(16'(base + k), salt) ||
            req_log[k].addr !== 16'(base + k) || wr_log[k].cyc != 3 * k + 4) begin
          miscompares++;
          $display("FAIL wait_wr%0d: got R%0d=%h a=%h cyc=%0d expected R%0d=%h a=%h cyc=%0d", k, wr_log[k].a3,
                   wr_log[k].d3, req_log[k].addr, wr_log[k].cyc, k, mem_fn(16'(base + k), salt), 16'(base + k), 3 * k + 4);
        end
      end
    end
    vectors++;
    if (done_cyc != 25 || xfer_at_done !== 4'd8) begin
      miscompares++;
      $display("FAIL wait_done: got cyc=%0d xfer=%0d expected cyc=25 xfer=8", done_cyc, xfer_at_done);
    end
  endtask

  task automatic test_abort();
    logic [15:0] base;
    base = 16'($urandom);
    for (int i = 0; i < 8; i++) rf_model[i] = 16'($urandom);
    run_op(1'b0, 8'b1101_0110, base, 0, 1, 1'b0, 2);
    vectors++;
    if (req_log.size() != 2 || wr_log.size() != 0) begin
      miscompares++;
      $display("FAIL abort_traffic: got req=%0d wr=%0d expected 2/0", req_log.size(), wr_log.size());
    end
    vectors++;
    if (ab_snap !== '0) begin miscompares++; $display("FAIL abort_state: got %h expected 0", ab_snap); end
    vectors++;
    if (post_busy != 0) begin miscompares++; $display("FAIL abort_quiet: got %0d expected 0", post_busy); end
    run_op(1'b1, 8'b0000_0011, base, 0, 0, 1'b0, 0);
    vectors++;
    if (done_cyc != 3 || wr_log.size() != 2 || xfer_at_done !== 4'd2) begin
      miscompares++;
      $display("FAIL abort_restart: got cyc=%0d wr=%0d xfer=%0d expected 3/2/2", done_cyc, wr_log.size(), xfer_at_done);
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] base;
    logic [7:0]  mask;
    int          n;
    base = 16'($urandom);
    mask = 8'($urandom) | 8'h21;
    n = $countones(mask);
    run_op(1'b1, mask, base, 0, 1, 1'b1, 0);
    vectors++;
    if (req_log.size() != n || wr_log.size() != n) begin
      miscompares++;
      $display("FAIL spam_counts: got req=%0d wr=%0d expected %0d", req_log.size(), wr_log.size(), n);
    end else begin
      vectors++;
      if (req_log[n-1].addr !== 16'(base + n - 1) || req_log[0].we !== 1'b0) begin
        miscompares++;
        $display("FAIL spam_latched: got last=%h we=%b expected %h we=0", req_log[n-1].addr, req_log[0].we,
                 16'(base + n - 1));
      end
    end
    vectors++;
    if (post_busy != 0 || xfer_at_done !== 4'(n)) begin
      miscompares++;
      $display("FAIL spam_done: got post=%0d xfer=%0d expected 0/%0d", post_busy, xfer_at_done, n);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      bit          ld;
      logic [7:0]  mask;
      logic [15:0] base;
      logic [2:0]  idx[$];
      int          n, exp_done;
      ld   = 1'($urandom_range(0, 1));
      mask = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      base = 16'($urandom);
      for (int i = 0; i < 8; i++) rf_model[i] = 16'($urandom);
      for (int i = 0; i < 8; i++) if (mask[i]) idx.push_back(3'(i));
      n = idx.size();
      run_op(ld, mask, base, 0, int'($urandom_range(0, 3)), 1'b0, 0);
      vectors++;
      if (req_log.size() != n || wr_log.size() != (ld ? n : 0)) begin
        miscompares++;
        $display("FAIL rnd%0d_counts: got req=%0d wr=%0d expected %0d/%0d", it, req_log.size(), wr_log.size(),
                 n, ld ? n : 0);
        continue;
      end
      for (int k = 0; k < n; k++) begin
        vectors++;
        if (req_log[k].addr !== 16'(base + k) || req_log[k].we !== !ld || req_log[k].a2 !== idx[k] ||
            (!ld && req_log[k].wdata !== rf_model[idx[k]])) begin
          miscompares++;
          $display("FAIL rnd%0d_req%0d: got a=%h we=%b r=%0d d=%h expected a=%h we=%b r=%0d", it, k, req_log[k].addr,
                   req_log[k].we, req_log[k].a2, req_log[k].wdata, 16'(base + k), !ld, idx[k]);
        end
        if (ld) begin
          vectors++;
          if (wr_log[k].a3 !== idx[k] || wr_log[k].d3 !== mem_fn(16'(base + k), salt) ||
              wr_log[k].cyc != req_log[k].cyc + 1) begin
            miscompares++;
            $display("FAIL rnd%0d_wr%0d: got R%0d=%h cyc=%0d expected R%0d=%h cyc=%0d", it, k, wr_log[k].a3,
                     wr_log[k].d3, wr_log[k].cyc, idx[k], mem_fn(16'(base + k), salt), req_log[k].cyc + 1);
          end
        end
      end
      exp_done = (n == 0) ? 1 : req_log[n-1].cyc + 1;
      vectors++;
      if (done_cyc != exp_done || xfer_at_done !== 4'(n) || timed_out) begin
        miscompares++;
        $display("FAIL rnd%0d_done: got cyc=%0d xfer=%0d to=%0b expected cyc=%0d xfer=%0d", it, done_cyc,
                 xfer_at_done, timed_out, exp_done, n);
      end
      vectors++;
      if (busy_bad != 0 || post_busy != 0 || stable_bad != 0 || pc_hold_bad != 0) begin
        miscompares++;
        $display("FAIL rnd%0d_ctl: got busy=%0d post=%0d stab=%0d pch=%0d expected 0", it, busy_bad, post_busy,
                 stable_bad, pc_hold_bad);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf_model[i] = '0;
    salt = '0;
    test_reset();
    test_lm_basic();
    test_sm_wrap();
    test_zero_mask();
    test_lm_wait();
    test_abort();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
